// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - in-order instruction fetch stage with response queue and flush discard
module fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        bubble_out
);

    localparam int QAW    = $clog2(FIFO_DEPTH);
    localparam int QCW    = QAW + 1;
    localparam int CW     = $clog2(MAX_OUTSTANDING) + 1;
    localparam int TAW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int TDEPTH = 1 << TAW;
    localparam int SW     = ((QCW > CW) ? QCW : CW) + 1;

    logic [31:0]    fetch_pc;
    logic [31:0]    q_pc    [FIFO_DEPTH];
    logic [31:0]    q_instr [FIFO_DEPTH];
    logic [QAW-1:0] q_wr;
    logic [QAW-1:0] q_rd;
    logic [QCW-1:0] q_count;
    logic [31:0]    tag_pc  [TDEPTH];
    logic [TAW-1:0] tag_wr;
    logic [TAW-1:0] tag_rd;
    logic [CW-1:0]  outstanding;
    logic [CW-1:0]  discard;

    logic           accept;
    logic           rsp;
    logic           push;
    logic           pop;
    logic           q_empty;
    logic [SW-1:0]  reserved;

    // Every in-flight read holds a queue slot, so a returning word always fits.
    always_comb begin
        q_empty  = (q_count == '0);
        reserved = SW'(q_count) + SW'(outstanding);
        imem_req = rst_n && !halt && !flush
                   && (outstanding < CW'(MAX_OUTSTANDING))
                   && (reserved < SW'(FIFO_DEPTH));
        accept   = imem_req && imem_ready;
        rsp      = imem_rvalid && (outstanding != '0);
        push     = rsp && !flush && (discard == '0);
        pop      = !q_empty && !stall && !halt && !flush;
    end

    assign imem_addr  = fetch_pc;
    assign instr_out  = q_empty ? '0 : q_instr[q_rd];
    assign pc_out     = q_empty ? '0 : q_pc[q_rd];
    assign bubble_out = q_empty || flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            q_wr        <= '0;
            q_rd        <= '0;
            q_count     <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else if (flush) begin
            // Reads still in flight after this edge all return as stale data.
            fetch_pc    <= redirect_pc;
            q_wr        <= '0;
            q_rd        <= '0;
            q_count     <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            outstanding <= outstanding - CW'(rsp);
            discard     <= outstanding - CW'(rsp);
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
                tag_wr   <= tag_wr + TAW'(1);
            end
            outstanding <= outstanding + CW'(accept) - CW'(rsp);
            if (rsp && (discard != '0)) begin
                discard <= discard - CW'(1);
            end
            if (push) begin
                tag_rd <= tag_rd + TAW'(1);
                q_wr   <= q_wr + QAW'(1);
            end
            if (pop) begin
                q_rd <= q_rd + QAW'(1);
            end
            q_count <= q_count + QCW'(push) - QCW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !flush) begin
            tag_pc[tag_wr] <= fetch_pc;
        end
        if (push) begin
            q_pc[q_wr]    <= tag_pc[tag_rd];
            q_instr[q_wr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector bench for fetch_unit with a latency-programmable memory model
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        halt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        bubble_out;

    int checks   = 0;
    int failures = 0;

    // memory model: word at address a is a + INSTR_OFS, returned L cycles after acceptance
    localparam logic [31:0] INSTR_OFS = 32'h1000_0000;
    int          lat;
    int          cyc;
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];

    typedef struct {
        logic        stall;
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic        bub;
        logic [31:0] pc;
    } vec_t;

    vec_t vt[28];

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .halt        (halt),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .bubble_out  (bubble_out)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic s, input logic r, input logic q,
                                input logic [31:0] a, input logic b, input logic [31:0] p);
        vec_t v;
        v.stall = s;
        v.ready = r;
        v.req   = q;
        v.addr  = a;
        v.bub   = b;
        v.pc    = p;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one clock edge: record acceptance before the edge, then drive this cycle's response
    task automatic step();
        logic        acc;
        logic [31:0] a;
        acc = imem_req && imem_ready;
        a   = imem_addr;
        @(posedge clk);
        #1;
        cyc++;
        if (acc) begin
            mem_addr_q.push_back(a);
            mem_due_q.push_back(cyc + lat - 1);
        end
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_addr_q[0] + INSTR_OFS;
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end
    endtask

    task automatic hold_reset(input int l);
        rst_n       = 1'b0;
        flush       = 1'b0;
        redirect_pc = '0;
        stall       = 1'b0;
        halt        = 1'b0;
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        lat         = l;
        mem_addr_q.delete();
        mem_due_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic wait_word(input string name, input logic [31:0] exp_pc);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            #1;
            if (!bubble_out) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: no word after 20 cycles, expected pc %h", name, exp_pc);
        end else begin
            chk({name, "_pc"}, pc_out, exp_pc);
            chk({name, "_instr"}, instr_out, exp_pc + INSTR_OFS);
        end
    endtask

    initial begin
        // latency-1 stream with a 5-cycle stall, then imem_ready low for 10 cycles
        vt[0]  = mk(0, 1, 1, 32'd0,  1, 32'd0);
        vt[1]  = mk(0, 1, 1, 32'd4,  1, 32'd0);
        vt[2]  = mk(0, 1, 1, 32'd8,  0, 32'd0);
        vt[3]  = mk(0, 1, 1, 32'd12, 0, 32'd4);
        vt[4]  = mk(1, 1, 1, 32'd16, 0, 32'd8);
        vt[5]  = mk(1, 1, 1, 32'd20, 0, 32'd8);
        vt[6]  = mk(1, 1, 0, 32'd24, 0, 32'd8);
        vt[7]  = mk(1, 1, 0, 32'd24, 0, 32'd8);
        vt[8]  = mk(1, 1, 0, 32'd24, 0, 32'd8);
        vt[9]  = mk(0, 1, 0, 32'd24, 0, 32'd8);
        vt[10] = mk(0, 1, 1, 32'd24, 0, 32'd12);
        vt[11] = mk(0, 1, 1, 32'd28, 0, 32'd16);
        vt[12] = mk(0, 1, 1, 32'd32, 0, 32'd20);
        vt[13] = mk(0, 1, 1, 32'd36, 0, 32'd24);
        vt[14] = mk(0, 1, 1, 32'd40, 0, 32'd28);
        vt[15] = mk(0, 0, 1, 32'd44, 0, 32'd32);
        vt[16] = mk(0, 0, 1, 32'd44, 0, 32'd36);
        vt[17] = mk(0, 0, 1, 32'd44, 0, 32'd40);
        for (int i = 18; i < 25; i++) vt[i] = mk(0, 0, 1, 32'd44, 1, 32'd0);
        vt[25] = mk(0, 1, 1, 32'd44, 1, 32'd0);
        vt[26] = mk(0, 1, 1, 32'd48, 1, 32'd0);
        vt[27] = mk(0, 1, 1, 32'd52, 0, 32'd44);

        hold_reset(1);
        chk("reset_req",    32'(imem_req),   32'd0);
        chk("reset_bubble", 32'(bubble_out), 32'd1);
        chk("reset_pc",     pc_out,          32'd0);
        chk("reset_instr",  instr_out,       32'd0);
        chk("reset_addr",   imem_addr,       32'd0);
        release_reset();

        for (int i = 0; i < 28; i++) begin
            if (i > 0) step();
            stall      = vt[i].stall;
            imem_ready = vt[i].ready;
            #1;
            chk($sformatf("row%0d_req", i),    32'(imem_req),   32'(vt[i].req));
            chk($sformatf("row%0d_addr", i),   imem_addr,       vt[i].addr);
            chk($sformatf("row%0d_bubble", i), 32'(bubble_out), 32'(vt[i].bub));
            chk($sformatf("row%0d_pc", i),     pc_out,          vt[i].pc);
            chk($sformatf("row%0d_instr", i),  instr_out,
                vt[i].bub ? 32'd0 : vt[i].pc + INSTR_OFS);
        end

        // latency 3: reads at 0x10/0x14 in flight when redirected to 0x100
        hold_reset(3);
        release_reset();
        flush       = 1'b1;
        redirect_pc = 32'h10;
        #1;
        chk("f3_c0_req", 32'(imem_req), 32'd0);
        step();
        flush = 1'b0;
        #1;
        chk("f3_c1_addr", imem_addr, 32'h10);
        step();
        #1;
        chk("f3_c2_addr", imem_addr, 32'h14);
        step();
        flush       = 1'b1;
        redirect_pc = 32'h100;
        #1;
        chk("f3_flush_bubble", 32'(bubble_out), 32'd1);
        chk("f3_flush_req",    32'(imem_req),   32'd0);
        step();
        flush = 1'b0;
        #1;
        chk("f3_c4_req_blocked", 32'(imem_req), 32'd0);
        step();
        #1;
        chk("f3_c5_req",  32'(imem_req), 32'd1);
        chk("f3_c5_addr", imem_addr,     32'h100);
        wait_word("f3_first", 32'h100);
        step();
        #1;
        chk("f3_second_pc", pc_out, 32'h104);

        // latency 2: flush with stall in the same cycle a response returns
        hold_reset(2);
        release_reset();
        #1;
        step();
        #1;
        step();
        flush       = 1'b1;
        stall       = 1'b1;
        redirect_pc = 32'h200;
        #1;
        chk("f4_flush_bubble", 32'(bubble_out), 32'd1);
        chk("f4_flush_req",    32'(imem_req),   32'd0);
        step();
        flush = 1'b0;
        #1;
        chk("f4_c3_req",    32'(imem_req),   32'd1);
        chk("f4_c3_addr",   imem_addr,       32'h200);
        chk("f4_c3_bubble", 32'(bubble_out), 32'd1);
        stall = 1'b0;
        wait_word("f4_first", 32'h200);

        // halt with one read in flight, spurious rvalid, then asynchronous reset
        hold_reset(2);
        release_reset();
        halt        = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        #1;
        chk("h_c0_req", 32'(imem_req), 32'd0);
        step();
        halt = 1'b0;
        #1;
        chk("h_spurious_bubble", 32'(bubble_out), 32'd1);
        chk("h_c1_addr",         imem_addr,       32'd0);
        step();
        halt = 1'b1;
        #1;
        chk("h_c2_req",  32'(imem_req), 32'd0);
        chk("h_c2_addr", imem_addr,     32'd4);
        step();
        #1;
        step();
        #1;
        chk("h_c4_bubble", 32'(bubble_out), 32'd0);
        chk("h_c4_instr",  instr_out,       INSTR_OFS);
        step();
        #1;
        chk("h_c5_pc",     pc_out,          32'd0);
        chk("h_c5_bubble", 32'(bubble_out), 32'd0);
        chk("h_c5_req",    32'(imem_req),   32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("h_async_bubble", 32'(bubble_out), 32'd1);
        chk("h_async_instr",  instr_out,       32'd0);
        chk("h_async_req",    32'(imem_req),   32'd0);
        halt = 1'b0;
        @(posedge clk);
        #1;
        chk("h_rst_hold_req",  32'(imem_req), 32'd0);
        chk("h_rst_hold_addr", imem_addr,     32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
